// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART receiver: parity encodings,
// receiver FSM states and the baud-period helper.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } rx_state_e;

  // System clocks per serial bit.
  function automatic int baud_cycle(input int clk_fre_mhz, input int baud);
    return clk_fre_mhz * 1000000 / baud;
  endfunction

endpackage

// File: rtl/uart_rx_sync_fifo.sv
// Synchronous FIFO for received words. When empty, the output holds the last
// popped word (0 after reset).
module uart_rx_sync_fifo #(
  parameter int W     = 10,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_din,
  input  logic         i_pop,
  output logic [W-1:0] o_dout,
  output logic         o_full,
  output logic         o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0]   r_cnt;
  logic [W-1:0]  r_last;
  logic          w_pop, w_push;

  assign o_full  = (r_cnt == (AW+1)'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign w_pop   = i_pop & ~o_empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign w_push  = i_push & (~o_full | w_pop);
  assign o_dout  = o_empty ? r_last : r_mem[r_rd];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr   <= '0;
      r_rd   <= '0;
      r_cnt  <= '0;
      r_last <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop) begin
        r_rd   <= r_rd + 1'b1;
        r_last <= r_mem[r_rd];
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_fifo_param.sv
// Parametrised UART receiver with per-word parity/framing flags and an output FIFO.
// Define UART_RX_MAJORITY_EN for 2-of-3 voting around each bit centre.
module uart_rx_fifo_param
  import uart_pkg::*;
#(
  parameter int CLK_FRE    = 50,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_pin,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_perr,
  output logic                 rx_ferr,
  output logic                 rx_data_valid,
  input  logic                 rx_data_ready,
  output logic                 rx_overrun,
  output logic                 rx_busy
);
  localparam int          CYCLE       = baud_cycle(CLK_FRE, BAUD_RATE);
  localparam logic [15:0] C_MID       = 16'(CYCLE/2 - 1);
  localparam logic [15:0] C_END       = 16'(CYCLE - 1);
  localparam logic [3:0]  C_LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]  C_LAST_STOP = 4'(STOP_BITS - 1);
  localparam logic        C_ODD       = (PARITY == PARITY_ODD);

  rx_state_e            r_state, w_next;
  logic [1:0]           r_sync;
  logic                 r_rx_d;
  logic [15:0]          r_cnt;
  logic [3:0]           r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_perr, r_ferr;
  logic                 w_rx, w_fall, w_bit, w_mid, w_end, w_push, w_full, w_empty;

  assign w_rx   = r_sync[1];
  assign w_fall = r_rx_d & ~w_rx;
  assign w_mid  = (r_cnt == C_MID);
  assign w_end  = (r_cnt == C_END);

`ifdef UART_RX_MAJORITY_EN
  // At the decision cycle r_rx_d, w_rx and r_sync[0] hold the line at CYCLE/2-2, -1 and CYCLE/2.
  assign w_bit = (r_rx_d & w_rx) | (r_rx_d & r_sync[0]) | (w_rx & r_sync[0]);
`else
  assign w_bit = w_rx;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_push = 1'b0;
    case (r_state)
      S_IDLE:   if (w_fall) w_next = S_START;
      S_START: begin
        if (w_mid && w_bit) w_next = S_IDLE;
        else if (w_end)     w_next = S_DATA;
      end
      S_DATA:   if (w_end && r_bit_cnt == C_LAST_DATA)
                  w_next = (PARITY == PARITY_NONE) ? S_STOP : S_PARITY;
      S_PARITY: if (w_end) w_next = S_STOP;
      S_STOP: begin
        // Leave at the last stop bit's centre so a back-to-back start edge is not missed.
        if (w_mid && r_bit_cnt == C_LAST_STOP) begin
          w_push = 1'b1;
          w_next = w_bit ? S_IDLE : S_BREAK;
        end
      end
      S_BREAK:  if (w_rx) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync    <= 2'b11;
      r_rx_d    <= 1'b1;
      r_cnt     <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_perr    <= 1'b0;
      r_ferr    <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], rx_pin};
      r_rx_d <= w_rx;
      if (r_state == S_IDLE || r_state == S_BREAK || w_next != r_state || w_end)
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + 16'd1;
      if (w_next != r_state) r_bit_cnt <= '0;
      else if (w_end)        r_bit_cnt <= r_bit_cnt + 4'd1;
      if (r_state == S_START) begin
        r_perr <= 1'b0;
        r_ferr <= 1'b0;
      end
      if (r_state == S_DATA && w_mid)   r_shift <= {w_bit, r_shift[DATA_BITS-1:1]};
      if (r_state == S_PARITY && w_mid) r_perr  <= ^r_shift ^ w_bit ^ C_ODD;
      if (r_state == S_STOP && w_mid && !w_bit) r_ferr <= 1'b1;
    end
  end

  uart_rx_sync_fifo #(
    .W     (DATA_BITS + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_din   ({r_ferr | ~w_bit, r_perr, r_shift}),
    .i_pop   (rx_data_ready),
    .o_dout  ({rx_ferr, rx_perr, rx_data}),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign rx_data_valid = ~w_empty;
  assign rx_overrun    = w_push & w_full & ~rx_data_ready;
  assign rx_busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_fifo_param.sv
// Bench for uart_rx_fifo_param: 8E1, CYCLE=32, 4-deep FIFO. Vector table,
// hand sequences for glitch/overrun/reset, and a randomized scoreboard run.
module tb_uart_rx_fifo_param;
  localparam int CYC = 32;
  localparam int DB  = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rx_pin = 1'b1;
  logic          rx_data_ready;
  logic [DB-1:0] rx_data;
  logic          rx_perr, rx_ferr, rx_data_valid, rx_overrun, rx_busy;

  uart_rx_fifo_param #(
    .CLK_FRE(16), .BAUD_RATE(500000), .DATA_BITS(DB),
    .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .rx_pin(rx_pin), .rx_data(rx_data),
    .rx_perr(rx_perr), .rx_ferr(rx_ferr), .rx_data_valid(rx_data_valid),
    .rx_data_ready(rx_data_ready), .rx_overrun(rx_overrun), .rx_busy(rx_busy)
  );

  always #5 clk = ~clk;

  int         n_tests = 0, n_fail = 0, ovr_cnt = 0, rdy_mode = 1;
  logic [9:0] got [$];
  logic [9:0] expq [$];
  logic       busy_seen;

  // Consumer: ready chosen first, then the handshake that the next edge will see is logged.
  always @(negedge clk) begin
    case (rdy_mode)
      0:       rx_data_ready = 1'b0;
      1:       rx_data_ready = 1'b1;
      default: rx_data_ready = 1'($urandom_range(0, 1));
    endcase
    if (!rst) begin
      if (rx_data_valid && rx_data_ready) got.push_back({rx_ferr, rx_perr, rx_data});
      if (rx_overrun) ovr_cnt++;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input int n);
    rx_pin = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d, input logic pbit, input logic stopv,
                      input int low_bits, input int gap_bits);
    drive(1'b0, CYC);
    for (int i = 0; i < DB; i++) drive(d[i], CYC);
    drive(pbit, CYC);
    drive(stopv, CYC);
    if (!stopv) begin
      drive(1'b0, low_bits*CYC);
      busy_seen = rx_busy;
    end
    drive(1'b1, gap_bits*CYC);
  endtask

  typedef struct {
    logic [7:0] d;
    logic       p;
    logic       stop;
    int         low;
    int         gap;
    logic [9:0] exp;   // {ferr, perr, data}
  } vec_t;

  vec_t tbl [7];

  initial begin
    int n0, o0, k;
    logic [7:0] d;
    logic flip, bad, pb;

    tbl[0] = '{8'h55, 1'b0, 1'b1, 0, 0, 10'h055};
    tbl[1] = '{8'hA3, 1'b0, 1'b1, 0, 2, 10'h0A3};
    tbl[2] = '{8'h07, 1'b0, 1'b1, 0, 2, 10'h107};
    tbl[3] = '{8'h07, 1'b1, 1'b1, 0, 2, 10'h007};
    tbl[4] = '{8'h3C, 1'b0, 1'b0, 2, 2, 10'h23C};
    tbl[5] = '{8'hFF, 1'b1, 1'b1, 0, 1, 10'h1FF};
    tbl[6] = '{8'h00, 1'b0, 1'b1, 0, 1, 10'h000};

    repeat (4) @(negedge clk);
    check("reset_valid", rx_data_valid, 0);
    check("reset_busy",  rx_busy, 0);
    check("reset_data",  {rx_ferr, rx_perr, rx_data}, 0);
    check("reset_ovr",   rx_overrun, 0);
    rst = 1'b0;
    drive(1'b1, CYC);

    for (int i = 0; i < 7; i++) begin
      n0 = got.size(); o0 = ovr_cnt;
      send(tbl[i].d, tbl[i].p, tbl[i].stop, tbl[i].low, tbl[i].gap);
      check($sformatf("vec%0d_count", i), got.size(), n0 + 1);
      if (got.size() > n0) check($sformatf("vec%0d_word", i), got[n0], tbl[i].exp);
      check($sformatf("vec%0d_no_ovr", i), ovr_cnt, o0);
      if (!tbl[i].stop) begin
        check("break_busy_low_line", busy_seen, 1);
        check("break_busy_after", rx_busy, 0);
      end
    end
    check("hold_last_popped", {rx_ferr, rx_perr, rx_data}, 10'h000);

    // false start: short low glitch on idle line
    n0 = got.size();
    drive(1'b0, 12);
    check("glitch_busy", rx_busy, 1);
    rx_pin = 1'b1;
    k = 12;
    while (rx_busy && k < 100) begin @(negedge clk); k++; end
    check("glitch_busy_fall_window", (k >= 17 && k <= 21), 1);
    drive(1'b1, CYC);
    check("glitch_no_push", got.size(), n0);

    // overrun: 5 back-to-back frames into a stalled 4-deep FIFO
    rdy_mode = 0;
    drive(1'b1, 4);
    n0 = got.size(); o0 = ovr_cnt;
    for (int i = 1; i <= 5; i++) begin
      d = 8'(i * 8'h11);
      send(d, ^d, 1'b1, 0, 0);
    end
    drive(1'b1, CYC);
    check("ovr_pulses", ovr_cnt - o0, 1);
    check("ovr_held", got.size(), n0);
    check("ovr_valid", rx_data_valid, 1);
    check("ovr_head", rx_data, 8'h11);
    rdy_mode = 1;
    drive(1'b1, 10);
    check("ovr_drain_count", got.size(), n0 + 4);
    for (int i = 0; i < 4 && n0 + i < got.size(); i++)
      check($sformatf("ovr_drain%0d", i), got[n0+i], {2'b00, 8'(8'h11 * (i + 1))});
    check("ovr_empty", rx_data_valid, 0);

    // reset mid-frame discards the partial word
    n0 = got.size();
    drive(1'b0, CYC); drive(1'b1, 2*CYC); drive(1'b0, CYC/2);
    rx_pin = 1'b1; rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", rx_busy, 0);
    check("rst_valid", rx_data_valid, 0);
    check("rst_data", {rx_ferr, rx_perr, rx_data}, 0);
    drive(1'b1, 12*CYC);
    check("rst_no_partial", got.size(), n0);
    send(8'hC3, 1'b0, 1'b1, 0, 1);
    check("rst_resend_count", got.size(), n0 + 1);
    if (got.size() > n0) check("rst_resend_word", got[n0], 10'h0C3);

`ifdef UART_RX_MAJORITY_EN
    // 1-cycle high spike at the centre of bit 3 of 0x00 is outvoted
    n0 = got.size();
    drive(1'b0, CYC); drive(1'b0, 3*CYC);
    drive(1'b0, CYC/2); drive(1'b1, 1); drive(1'b0, CYC/2 - 1);
    drive(1'b0, 4*CYC); drive(1'b0, CYC); drive(1'b1, 2*CYC);
    check("maj_count", got.size(), n0 + 1);
    if (got.size() > n0) check("maj_word", got[n0], 10'h000);
`endif

    // randomized frames against a word-level scoreboard
    n0 = got.size(); o0 = ovr_cnt;
    expq.delete();
    rdy_mode = 2;
    for (int i = 0; i < 24; i++) begin
      d    = 8'($urandom);
      flip = ($urandom_range(0, 3) == 0);
      bad  = ($urandom_range(0, 7) == 0);
      pb   = (^d) ^ flip;
      expq.push_back({bad, ((^d) ^ pb) != 1'b0, d});
      send(d, pb, ~bad, bad ? 1 : 0, bad ? 1 : int'($urandom_range(0, 2)));
    end
    rdy_mode = 1;
    drive(1'b1, 20);
    check("rand_count", got.size() - n0, expq.size());
    for (int i = 0; i < expq.size() && n0 + i < got.size(); i++)
      check($sformatf("rand_word%0d", i), got[n0+i], expq[i]);
    check("rand_no_ovr", ovr_cnt, o0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
